frame_sequencer: RTL and testbench

- Front-end controller ahead of the FAST→BRIEF→MATCH pipeline in CHIP. It admits one raster frame at a time from an external pixel source and pulses the frame start toward FAST.
- It forwards exactly WIDTH×HEIGHT pixels under FAST's ready backpressure. It then blocks the source until MATCH reports frame end, or until a drain timeout expires.
- Provides frame count and sticky error status.

---
 rtl/frame_sequencer.sv | 163 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Purpose  : Admits one raster frame at a time, forwards WIDTH x HEIGHT pixels
//            to FAST under backpressure, then waits for MATCH frame end.
// Revision : 1.0
// ============================================================================
module frame_sequencer #(
    parameter logic [11:0] WIDTH         = 12'd640,
    parameter logic [11:0] HEIGHT        = 12'd480,
    parameter logic [23:0] DRAIN_TIMEOUT = 24'd2000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_pixel,
    input  logic        i_valid,
    input  logic        i_sof,
    output logic        o_ready,
    output logic [7:0]  o_pixel,
    output logic        o_valid,
    output logic        o_frame_start,
    input  logic        i_fast_ready,
    input  logic        i_match_frame_end,
    input  logic        i_clr_status,
    output logic [1:0]  o_state,
    output logic [15:0] o_frame_cnt,
    output logic        o_err_sof,
    output logic        o_timeout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [23:0] drain_q, drain_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_sof_q, err_sof_d;
    logic        timeout_q, timeout_d;
    logic        frame_start_q, frame_start_d;

    logic w_xfer;
    logic w_line_end;
    logic w_last_px;
    logic w_sof_detect;
    logic w_drain_expired;

    assign w_xfer          = (state_q == ST_STREAM) & i_valid & i_fast_ready;
    assign w_line_end      = (x_q == WIDTH - 12'd1);
    assign w_last_px       = w_line_end & (y_q == HEIGHT - 12'd1);
    assign w_sof_detect    = (state_q == ST_IDLE) & i_valid & i_sof;
    assign w_drain_expired = (drain_q == DRAIN_TIMEOUT - 24'd1);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_sof_detect) state_d = ST_START;
            ST_START:  state_d = ST_STREAM;
            ST_STREAM: if (w_xfer && w_last_px) state_d = ST_DRAIN;
            ST_DRAIN:  if (i_match_frame_end || w_drain_expired) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are combinational so STREAM runs at zero latency
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_pixel = i_pixel;
        if (i_rst_n) begin
            case (state_q)
                ST_IDLE:   o_ready = i_valid & ~i_sof;
                ST_STREAM: begin
                    o_ready = i_fast_ready;
                    o_valid = i_valid & i_fast_ready;
                end
                default:   o_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        drain_d       = 24'd0;
        frame_cnt_d   = frame_cnt_q;
        err_sof_d     = err_sof_q;
        timeout_d     = timeout_q;
        frame_start_d = w_sof_detect;

        if (i_clr_status) begin
            err_sof_d = 1'b0;
            timeout_d = 1'b0;
        end

        if (w_xfer) begin
            // The SOF pixel itself sits at (0,0); any later SOF is an error
            if (i_sof && ((x_q != 12'd0) || (y_q != 12'd0))) begin
                err_sof_d = 1'b1;
            end
            if (w_last_px) begin
                x_d = 12'd0;
                y_d = 12'd0;
            end else if (w_line_end) begin
                x_d = 12'd0;
                y_d = y_q + 12'd1;
            end else begin
                x_d = x_q + 12'd1;
            end
        end

        if (state_q == ST_DRAIN) begin
            if (i_match_frame_end) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else if (w_drain_expired) begin
                timeout_d = 1'b1;
            end else begin
                drain_d = drain_q + 24'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x_q           <= 12'd0;
            y_q           <= 12'd0;
            drain_q       <= 24'd0;
            frame_cnt_q   <= 16'd0;
            err_sof_q     <= 1'b0;
            timeout_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            drain_q       <= drain_d;
            frame_cnt_q   <= frame_cnt_d;
            err_sof_q     <= err_sof_d;
            timeout_q     <= timeout_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_state       = state_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_err_sof     = err_sof_q;
    assign o_timeout     = timeout_q;
    assign o_frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sequencer
// Purpose  : Scoreboard bench for frame_sequencer (WIDTH=4, HEIGHT=2, TO=16).
// Revision : 1.0
// ============================================================================
module tb_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pixel;
    logic        valid;
    logic        sof;
    logic        ready;
    logic [7:0]  o_pixel;
    logic        o_valid;
    logic        frame_start;
    logic        fast_ready;
    logic        mend;
    logic        clr;
    logic [1:0]  state;
    logic [15:0] frame_cnt;
    logic        err_sof;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int fs_cyc = -100;
    int fs_cnt = 0;
    logic [7:0] exp_q[$];

    frame_sequencer #(
        .WIDTH         (12'd4),
        .HEIGHT        (12'd2),
        .DRAIN_TIMEOUT (24'd16)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_pixel           (pixel),
        .i_valid           (valid),
        .i_sof             (sof),
        .o_ready           (ready),
        .o_pixel           (o_pixel),
        .o_valid           (o_valid),
        .o_frame_start     (frame_start),
        .i_fast_ready      (fast_ready),
        .i_match_frame_end (mend),
        .i_clr_status      (clr),
        .o_state           (state),
        .o_frame_cnt       (frame_cnt),
        .o_err_sof         (err_sof),
        .o_timeout         (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected pixels whenever the DUT presents one
    always @(negedge clk) begin
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_pixel", {24'd0, o_pixel}, 32'hFFFF);
            end else begin
                check("pixel", {24'd0, o_pixel}, {24'd0, exp_q.pop_front()});
            end
        end
        if (rst_n && state == 2'd2 && !fast_ready) begin
            check("bp_ready", {31'd0, ready}, 32'd0);
            check("bp_valid", {31'd0, o_valid}, 32'd0);
        end
        if (frame_start) begin
            fs_cyc = cyc;
            fs_cnt++;
            check("fs_state", {30'd0, state}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int garbage, input int mid_sof, input bit bp, input int abort_after);
        int idx;
        int guard;
        int sof_cyc;
        int fs0;
        bit xfer;
        fs0 = fs_cnt;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
        for (int g = 0; g < garbage; g++) begin
            valid = 1'b1;
            sof   = 1'b0;
            pixel = 8'hA0 + 8'(g);
            @(negedge clk);
            check("garbage_ready", {31'd0, ready}, 32'd1);
            tick();
        end
        idx = 0;
        guard = 0;
        sof_cyc = -1;
        while (idx < 8 && guard < 200) begin
            valid      = 1'b1;
            pixel      = 8'h10 + 8'(idx);
            sof        = (idx == 0) || (idx == mid_sof);
            fast_ready = bp ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            if (state == 2'd0) sof_cyc = cyc;
            xfer = ready;
            tick();
            guard++;
            if (xfer) begin
                idx++;
                if (idx - 1 == mid_sof) check("err_sof_set", {31'd0, err_sof}, 32'd1);
                if (abort_after != 0 && idx == abort_after) break;
            end
        end
        if (guard >= 200) check("frame_budget", guard, 0);
        valid      = 1'b0;
        sof        = 1'b0;
        fast_ready = 1'b1;
        if (abort_after == 0) begin
            check("drain_state", {30'd0, state}, 32'd3);
            check("fs_latency", fs_cyc, sof_cyc + 1);
            check("fs_pulses", fs_cnt - fs0, 1);
            check("queue_empty", exp_q.size(), 0);
        end
    endtask

    task automatic end_frame(input int wait_cycles);
        repeat (wait_cycles) tick();
        mend = 1'b1;
        tick();
        mend = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; pixel = 8'h00; valid = 1'b1; sof = 1'b1;
        fast_ready = 1'b1; mend = 1'b0; clr = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        tick();
        tick();
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_flags", {29'd0, err_sof, timeout, frame_start}, 32'd0);
        valid = 1'b0; sof = 1'b0;
        rst_n = 1'b1;
        tick();

        // Nominal frame
        run_frame(0, -1, 1'b0, 0);
        end_frame(4);
        check("t1_cnt", {16'd0, frame_cnt}, 32'd1);
        check("t1_state", {30'd0, state}, 32'd0);

        // Backpressure
        run_frame(0, -1, 1'b1, 0);
        end_frame(2);
        check("t2_cnt", {16'd0, frame_cnt}, 32'd2);

        // Pre-SOF garbage
        run_frame(3, -1, 1'b0, 0);
        end_frame(1);
        check("t3_cnt", {16'd0, frame_cnt}, 32'd3);
        check("t3_no_err", {31'd0, err_sof}, 32'd0);

        // Mid-frame SOF on transfer 5
        run_frame(0, 4, 1'b0, 0);
        check("t4_err", {31'd0, err_sof}, 32'd1);
        end_frame(0);
        check("t4_cnt", {16'd0, frame_cnt}, 32'd4);
        pulse_clr();
        check("t4_clr", {31'd0, err_sof}, 32'd0);

        // Drain timeout
        run_frame(0, -1, 1'b0, 0);
        n = 0;
        while (state == 2'd3 && n < 100) begin
            tick();
            n++;
        end
        check("t5_drain_len", n, 16);
        check("t5_timeout", {31'd0, timeout}, 32'd1);
        check("t5_cnt", {16'd0, frame_cnt}, 32'd4);
        pulse_clr();
        check("t5_clr", {31'd0, timeout}, 32'd0);
        run_frame(0, -1, 1'b0, 0);
        end_frame(15);
        check("t5_tie_cnt", {16'd0, frame_cnt}, 32'd5);
        check("t5_tie_timeout", {31'd0, timeout}, 32'd0);
        check("t5_tie_state", {30'd0, state}, 32'd0);

        // Reset mid-frame after 3 transfers
        run_frame(0, -1, 1'b0, 3);
        check("t6_leftover", exp_q.size(), 5);
        exp_q.delete();
        valid = 1'b1; pixel = 8'h13; fast_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_ready", {31'd0, ready}, 32'd0);
        check("t6_rst_valid", {31'd0, o_valid}, 32'd0);
        tick();
        check("t6_state", {30'd0, state}, 32'd0);
        check("t6_cnt", {16'd0, frame_cnt}, 32'd0);
        check("t6_flags", {29'd0, err_sof, timeout, frame_start}, 32'd0);
        rst_n = 1'b1;
        valid = 1'b0;
        tick();
        run_frame(0, -1, 1'b0, 0);
        end_frame(3);
        check("t6_cnt_after", {16'd0, frame_cnt}, 32'd1);

        tick();
        check("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
